cordic_quadrant_seq: RTL and testbench
======================================

CORDIC_QUADRANT_SEQ -- requirements
Module: cordic_quadrant_seq

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- WL, 16, word length of all angle and trig buses.
- FL_IN, 13, fraction bits of angle_in (Q2.13).
- TIMEOUT, 32, maximum cycles to wait for core completion.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- angle_in  in  WL  signed Q2.13 angle, nominal range [-pi, pi].
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- cos_out  out  WL  signed Q1.14 cosine.
- sin_out  out  WL  signed Q1.14 sine.
- err  out  1  result produced by timeout; qualified by out_valid.
- core_start  out  1  one-cycle start pulse to the downstream CORDIC core.
- core_angle  out  WL  signed Q1.14 angle to the core, within [-pi/2, pi/2].
- core_cos  in  WL  core cosine result, Q1.14.
- core_sin  in  WL  core sine result, Q1.14.
- core_done  in  1  core completion level.
REQ-003 The design SHALL use one clock, clk; reset rst_n SHALL be asynchronous, active-low.

Function
REQ-004 Constants SHALL be PI=25736, HALF_PI=12868, TWO_PI=51472 (Q2.13).
REQ-005 Range reduction SHALL use 17-bit signed arithmetic:
- a > PI: a - TWO_PI.
- a < -PI: a + TWO_PI.
- otherwise a unchanged.
REQ-006 Folding SHALL be:
- r > HALF_PI: f = PI - r, neg=1.
- r < -HALF_PI: f = -PI - r, neg=1.
- otherwise f = r, neg=0. r = ±HALF_PI exactly is not folded.
REQ-007 core_angle SHALL equal f shifted left by 1 (Q2.13 to Q1.14), registered and held stable from ISSUE until the next accepted request.
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
- IDLE: in_ready=1. in_valid&in_ready latches angle, computes f and neg, goes to ISSUE.
- ISSUE: core_start=1 for exactly one cycle, clear timeout counter, go to WAIT.
- WAIT: on a rising edge of core_done (core_done=1 now, 0 the previous cycle), capture results and go to HOLD. If the counter reaches TIMEOUT first, go to HOLD with err=1, cos_out=0, sin_out=0.
- HOLD: out_valid=1. out_valid&out_ready goes to IDLE.
REQ-009 A core_done held high from a prior operation SHALL NOT complete the current one; only a rising edge counts.
REQ-010 Results SHALL be sin_out=core_sin; cos_out=neg ? -core_cos : core_cos. Negation of -32768 saturates to 32767.
REQ-011 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored.
REQ-012 In HOLD, out_valid, cos_out, sin_out, err SHALL stay stable until accepted.
REQ-013 Latency SHALL be: accept at cycle 0, core_start at cycle 1, out_valid one cycle after the core_done rising edge.
REQ-014 Accepting a result in HOLD SHALL NOT take a new request in the same cycle; the earliest new accept is the following IDLE cycle.

Reset
REQ-015 While rst_n=0 the block SHALL hold:
- state=IDLE.
- in_ready=0, out_valid=0, core_start=0, err=0.
- cos_out=0, sin_out=0, core_angle=0, timeout counter=0.
REQ-016 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-017 Reset asserted in any state, including mid-WAIT, SHALL abort the operation with no out_valid; a later core_done edge SHALL be ignored unless a new request has been issued.

Verification
REQ-018 The bench SHALL cover at least these directed scenarios:
- angle_in=0; core returns cos 16384, sin 0 -> core_angle=0, cos_out=16384, sin_out=0, err=0.
- angle_in=25736 (pi); core returns 16384, 0 -> core_angle=0, cos_out=-16384, sin_out=0.
- angle_in=12868 -> core_angle=25736, no negation. angle_in=12869 -> core_angle=25734, cos negated.
- angle_in=-19302 -> core_angle=-12868; angle_in=30000 -> core_angle=-8528, cos negated.
- core_done held high from the previous op, no new edge for 32 cycles -> out_valid with err=1, cos_out=sin_out=0.
- out_ready low for 10 cycles in HOLD -> outputs stable, in_ready=0. rst_n pulsed mid-WAIT -> no out_valid, in_ready=1 next edge.

Source files
------------

// File: rtl/cordic_quadrant_seq_if.sv
// Request, result and CORDIC-core signal bundle for cordic_quadrant_seq.
// The slave modport is the sequencer's view; master is the environment's view.
interface cordic_quadrant_seq_if #(
    parameter int WL = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] angle_in;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] cos_out;
    logic [WL-1:0] sin_out;
    logic          err;
    logic          core_start;
    logic [WL-1:0] core_angle;
    logic [WL-1:0] core_cos;
    logic [WL-1:0] core_sin;
    logic          core_done;

    modport slave (
        input  in_valid, angle_in, out_ready, core_cos, core_sin, core_done,
        output in_ready, out_valid, cos_out, sin_out, err, core_start, core_angle
    );

    modport master (
        output in_valid, angle_in, out_ready, core_cos, core_sin, core_done,
        input  in_ready, out_valid, cos_out, sin_out, err, core_start, core_angle
    );
endinterface

// File: rtl/cordic_quadrant_seq.sv
// Quadrant pre/post-processing sequencer around a CORDIC core: reduces the
// angle into [-pi/2, pi/2], issues the core, and fixes up the cosine sign.
module cordic_quadrant_seq #(
    parameter int WL      = 16,
    parameter int FL_IN   = 13,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cordic_quadrant_seq_if.slave bus
);
    localparam int AW = WL + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SH = 14 - FL_IN;

    localparam logic signed [AW-1:0] PI          = AW'(25736);
    localparam logic signed [AW-1:0] HALF_PI     = AW'(12868);
    localparam logic signed [AW-1:0] TWO_PI      = AW'(51472);
    localparam logic signed [AW-1:0] NEG_PI      = -PI;
    localparam logic signed [AW-1:0] NEG_HALF_PI = -HALF_PI;

    localparam logic [WL-1:0] MIN_VAL = {1'b1, {(WL-1){1'b0}}};
    localparam logic [WL-1:0] MAX_VAL = {1'b0, {(WL-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            core_start_q, core_start_d;
    logic            err_q, err_d;
    logic [WL-1:0]   cos_q, cos_d;
    logic [WL-1:0]   sin_q, sin_d;
    logic [WL-1:0]   angle_q, angle_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            done_prev_q;
    logic            done_rise;

    logic signed [AW-1:0] a_ext, r_red, f_fold, f_sh;
    logic                 neg_fold;

    function automatic logic [WL-1:0] neg_sat(input logic [WL-1:0] v);
        if (v == MIN_VAL) return MAX_VAL;
        return -v;
    endfunction

    // Range reduction then fold into [-pi/2, pi/2]; exact +-pi/2 stays unfolded.
    always_comb begin
        a_ext = AW'($signed(bus.angle_in));
        r_red = a_ext;
        if (a_ext > PI)
            r_red = a_ext - TWO_PI;
        else if (a_ext < NEG_PI)
            r_red = a_ext + TWO_PI;

        f_fold   = r_red;
        neg_fold = 1'b0;
        if (r_red > HALF_PI) begin
            f_fold   = PI - r_red;
            neg_fold = 1'b1;
        end else if (r_red < NEG_HALF_PI) begin
            f_fold   = NEG_PI - r_red;
            neg_fold = 1'b1;
        end
        f_sh = f_fold <<< SH;
    end

    assign done_rise = bus.core_done & ~done_prev_q;
    assign cnt_inc   = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    angle_d = f_sh[WL-1:0];
                    neg_d   = neg_fold;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    cos_d   = neg_q ? neg_sat(bus.core_cos) : bus.core_cos;
                    sin_d   = bus.core_sin;
                    err_d   = 1'b0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT)) begin
                        cos_d   = '0;
                        sin_d   = '0;
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state so that reset
        // forces them low and in_ready only rises on the first edge after reset.
        in_ready_d   = (state_d == IDLE);
        out_valid_d  = (state_d == HOLD);
        core_start_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
            cos_q        <= '0;
            sin_q        <= '0;
            angle_q      <= '0;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
            done_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            core_start_q <= core_start_d;
            err_q        <= err_d;
            cos_q        <= cos_d;
            sin_q        <= sin_d;
            angle_q      <= angle_d;
            neg_q        <= neg_d;
            cnt_q        <= cnt_d;
            done_prev_q  <= bus.core_done;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.core_start = core_start_q;
    assign bus.err        = err_q;
    assign bus.cos_out    = cos_q;
    assign bus.sin_out    = sin_q;
    assign bus.core_angle = angle_q;
endmodule

// File: tb/tb_cordic_quadrant_seq.sv
// Directed bench for cordic_quadrant_seq: vector table for the angle folding
// and sign fix-up, plus hand sequences for timeout, back-pressure and reset.
module tb_cordic_quadrant_seq;
    localparam int WL = 16;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_quadrant_seq_if #(.WL(WL)) bus();

    cordic_quadrant_seq #(.WL(WL), .FL_IN(13), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int angle;
        int ccos;
        int csin;
        int exp_angle;
        int exp_cos;
        int exp_sin;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int s16(input logic [WL-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic wait_out(input int budget, output int cycles, output int ok);
        cycles = 0;
        ok = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (bus.out_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Drives one request at a negedge; returns after the accept edge.
    task automatic issue(input int angle, input string tag);
        chk({tag, " in_ready before accept"}, int'(bus.in_ready), 1);
        bus.angle_in = WL'(angle);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, " core_start latency"}, int'(bus.core_start), 1);
        chk({tag, " in_ready busy"}, int'(bus.in_ready), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        issue(v.angle, tag);
        chk({tag, " core_angle"}, s16(bus.core_angle), v.exp_angle);
        @(negedge clk);
        chk({tag, " core_start one cycle"}, int'(bus.core_start), 0);
        @(negedge clk);
        bus.core_cos  = WL'(v.ccos);
        bus.core_sin  = WL'(v.csin);
        bus.core_done = 1'b1;
        @(negedge clk);
        bus.core_done = 1'b0;
        chk({tag, " out_valid latency"}, int'(bus.out_valid), 1);
        chk({tag, " cos_out"}, s16(bus.cos_out), v.exp_cos);
        chk({tag, " sin_out"}, s16(bus.sin_out), v.exp_sin);
        chk({tag, " err"}, int'(bus.err), 0);
        chk({tag, " core_angle held"}, s16(bus.core_angle), v.exp_angle);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, " out_valid cleared"}, int'(bus.out_valid), 0);
        chk({tag, " in_ready after accept"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int ok;

        vecs[0] = '{0,      16384,  0,      0,      16384,  0};
        vecs[1] = '{25736,  16384,  0,      0,      -16384, 0};
        vecs[2] = '{12868,  100,    16384,  25736,  100,    16384};
        vecs[3] = '{12869,  5,      16383,  25734,  -5,     16383};
        vecs[4] = '{-19302, 200,    -300,   -12868, -200,   -300};
        vecs[5] = '{30000,  -32768, 1234,   -8528,  32767,  1234};
        vecs[6] = '{-25736, 16384,  -7,     0,      -16384, -7};
        vecs[7] = '{-12868, 32767,  -16384, -25736, 32767,  -16384};
        vecs[8] = '{32767,  1000,   2,      -14062, -1000,  2};
        vecs[9] = '{-32768, -1,     3,      14064,  1,      3};

        bus.in_valid  = 1'b0;
        bus.angle_in  = '0;
        bus.out_ready = 1'b0;
        bus.core_cos  = '0;
        bus.core_sin  = '0;
        bus.core_done = 1'b0;

        // Reset state, including in_valid presented during reset
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst in_ready", int'(bus.in_ready), 0);
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst core_start", int'(bus.core_start), 0);
        chk("rst err", int'(bus.err), 0);
        chk("rst cos_out", s16(bus.cos_out), 0);
        chk("rst sin_out", s16(bus.sin_out), 0);
        chk("rst core_angle", s16(bus.core_angle), 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("in_ready before first edge", int'(bus.in_ready), 0);
        @(negedge clk);
        chk("in_ready after first edge", int'(bus.in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure in HOLD with a competing request that must be ignored
        issue(12869, "hold");
        @(negedge clk);
        @(negedge clk);
        bus.core_cos  = WL'(777);
        bus.core_sin  = WL'(-888);
        bus.core_done = 1'b1;
        @(negedge clk);
        bus.core_done = 1'b0;
        bus.angle_in  = WL'(0);
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("hold%0d out_valid", c), int'(bus.out_valid), 1);
            chk($sformatf("hold%0d cos_out", c), s16(bus.cos_out), -777);
            chk($sformatf("hold%0d sin_out", c), s16(bus.sin_out), -888);
            chk($sformatf("hold%0d err", c), int'(bus.err), 0);
            chk($sformatf("hold%0d in_ready", c), int'(bus.in_ready), 0);
            chk($sformatf("hold%0d core_start", c), int'(bus.core_start), 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("hold release out_valid", int'(bus.out_valid), 0);
        chk("hold release no same-cycle accept", int'(bus.core_start), 0);
        chk("hold release in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("next accept core_start", int'(bus.core_start), 1);
        chk("next accept core_angle", s16(bus.core_angle), 0);
        @(negedge clk);
        bus.core_cos  = WL'(16384);
        bus.core_sin  = WL'(0);
        bus.core_done = 1'b1;
        // core_done is left high on purpose for the timeout sequence below
        @(negedge clk);
        chk("next accept out_valid", int'(bus.out_valid), 1);
        chk("next accept cos_out", s16(bus.cos_out), 16384);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Stale core_done level must not complete: expect timeout
        issue(0, "tmo");
        wait_out(TO + 8, cycles, ok);
        chk("tmo out_valid seen", ok, 1);
        chk("tmo not early", int'(cycles >= TO), 1);
        chk("tmo err", int'(bus.err), 1);
        chk("tmo cos_out", s16(bus.cos_out), 0);
        chk("tmo sin_out", s16(bus.sin_out), 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.core_done = 1'b0;
        chk("tmo in_ready after accept", int'(bus.in_ready), 1);
        @(negedge clk);

        // Reset pulsed mid-WAIT aborts the operation
        issue(12868, "rstw");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstw out_valid", int'(bus.out_valid), 0);
        chk("rstw in_ready", int'(bus.in_ready), 0);
        chk("rstw core_start", int'(bus.core_start), 0);
        chk("rstw core_angle", s16(bus.core_angle), 0);
        chk("rstw err", int'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw in_ready next edge", int'(bus.in_ready), 1);
        bus.core_cos  = WL'(123);
        bus.core_done = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rstw stale done%0d out_valid", c), int'(bus.out_valid), 0);
            chk($sformatf("rstw stale done%0d core_start", c), int'(bus.core_start), 0);
        end
        bus.core_done = 1'b0;
        @(negedge clk);
        run_vec(vecs[3], "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
